// File: rtl/instruction_encoder_loader.sv
// instruction_encoder_loader: packs decoded instruction fields into 32-bit words and streams them into instruction memory
//  clk, rst_n            clock, asynchronous active-low reset
//  start, base_addr      begin a program load at base_addr (ignored unless idle)
//  in_valid/in_ready     field bundle handshake; in_last marks the final instruction
//  funtype..imm          decoded fields to encode
//  mem_valid/mem_ready   instruction memory write handshake with mem_addr/mem_wdata
//  busy, done, enc_err   status: loading, one-cycle completion pulse, sticky immediate overflow
//  count                 words written since start
module instruction_encoder_loader #(
  parameter int bus = 32,
  parameter int AW = 10,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [1:0]    funtype,
  input  logic [1:0]    funcode,
  input  logic [3:0]    rd,
  input  logic [3:0]    rs,
  input  logic [3:0]    rx,
  input  logic          sel_imm,
  input  logic [27:0]   imm,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic [bus-1:0] mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          enc_err,
  output logic [AW:0]   count
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [bus-1:0] fifo [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] occ;
  logic [31:0] word;
  logic err, push, pop;
  always_comb begin
    word = '0;
    err = 1'b0;
    word[31:28] = {funtype, funcode};
    word[27:24] = rd;
    case (funtype)
      2'b00: begin
        // CMP leaves rs zero: decode recreates it from rd
        word[23:20] = funcode == 2'b11 ? 4'h0 : rs;
        if (sel_imm) word[19:0] = {imm[18:0], 1'b1};
        else word[19:16] = rx;
        err = sel_imm && |imm[27:19];
      end
      2'b01: word[23:16] = {rs, rx};
      2'b10: word[27:0] = {imm[27:1], 1'b1};
      default: begin
        if (funcode == 2'b10) word[23:20] = imm[3:0];
        else word[19:16] = rx;
        err = funcode == 2'b10 && |imm[27:4];
      end
    endcase
  end
  assign in_ready = state == RUN && occ != (PW+1)'(DEPTH);
  assign mem_valid = occ != '0;
  // gate the head so an empty FIFO shows zero rather than stale data
  assign mem_wdata = mem_valid ? fifo[rd_ptr] : '0;
  assign push = in_valid && in_ready;
  assign pop = mem_valid && mem_ready;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= word;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ <= '0;
      mem_addr <= '0;
      count <= '0;
      enc_err <= 1'b0;
    end else begin
      occ <= occ + (PW+1)'(push) - (PW+1)'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (push && err) enc_err <= 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        mem_addr <= mem_addr + 1'b1;
        count <= count + 1'b1;
      end
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          mem_addr <= base_addr;
          count <= '0;
          enc_err <= 1'b0;
        end
        RUN: if (push && in_last) state <= DRAIN;
        DRAIN: if (occ == '0) state <= DONE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_instruction_encoder_loader.sv
// tb_instruction_encoder_loader: randomized self-checking bench against a field-level encoding model
module tb_instruction_encoder_loader;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, in_last = 0, sel_imm = 0, mem_ready = 0;
  logic [9:0] base_addr = 0;
  logic [1:0] funtype = 0, funcode = 0;
  logic [3:0] rd = 0, rs = 0, rx = 0;
  logic [27:0] imm = 0;
  logic in_ready, mem_valid, busy, done, enc_err;
  logic [9:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [10:0] count;
  int total = 0, passed = 0;
  logic [41:0] obs_q[$], exp_q[$];
  logic [9:0] exp_addr;
  bit exp_err;
  instruction_encoder_loader #(.bus(32), .AW(10), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .funtype(funtype), .funcode(funcode), .rd(rd),
    .rs(rs), .rx(rx), .sel_imm(sel_imm), .imm(imm), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done), .enc_err(enc_err),
    .count(count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (mem_valid && mem_ready) obs_q.push_back({mem_addr, mem_wdata});
  function automatic logic [31:0] model(input logic [1:0] ft, fc, input logic [3:0] d, s, x,
                                        input logic si, input logic [27:0] im, output bit e);
    longint w, iv;
    iv = longint'(im);
    e = 0;
    w = longint'(ft) * 2**30 + longint'(fc) * 2**28;
    if (ft == 2) return 32'(w + (iv / 2) * 2 + 1);
    w += longint'(d) * 2**24;
    if (ft == 0) begin
      if (fc != 3) w += longint'(s) * 2**20;
      if (si) begin
        w += (iv % 2**19) * 2 + 1;
        e = iv >= 2**19;
      end else w += longint'(x) * 2**16;
    end else if (ft == 1) w += longint'(s) * 2**20 + longint'(x) * 2**16;
    else if (fc == 2) begin
      w += (iv % 16) * 2**20;
      e = iv >= 16;
    end else w += longint'(x) * 2**16;
    return 32'(w);
  endfunction
  task automatic go(input logic [9:0] b);
    @(posedge clk); #1;
    base_addr = b;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    exp_addr = b;
    exp_err = 0;
    obs_q.delete();
    exp_q.delete();
  endtask
  task automatic send(input logic [1:0] ft, fc, input logic [3:0] d, s, x, input logic si,
                      input logic [27:0] im, input logic last);
    bit e, ok;
    logic [31:0] w;
    w = model(ft, fc, d, s, x, si, im, e);
    @(posedge clk); #1;
    {funtype, funcode, rd, rs, rx, sel_imm, imm, in_last} = {ft, fc, d, s, x, si, im, last};
    in_valid = 1;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    in_valid = 0;
    in_last = 0;
    if (ok) begin
      exp_q.push_back({exp_addr, w});
      exp_addr++;
      exp_err |= e;
    end else begin
      total++;
      $display("FAIL send_accept: in_ready=0 required 1");
    end
  endtask
  task automatic send_rand(input logic last);
    logic [27:0] im;
    im = $urandom_range(0, 1) ? 28'($urandom_range(0, 2**19 - 1)) : 28'($urandom);
    if ($urandom_range(0, 3) == 0) im = 28'($urandom_range(0, 31));
    send(2'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), im, last);
  endtask
  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if ({in_ready, mem_valid, busy, done, enc_err} !== 5'b0) $display("FAIL reset_flags: got %b required 00000", {in_ready, mem_valid, busy, done, enc_err}); else passed++;
    total++; if (mem_addr !== 10'h0) $display("FAIL reset_addr: got %h required 000", mem_addr); else passed++;
    total++; if (mem_wdata !== 32'h0) $display("FAIL reset_wdata: got %h required 0", mem_wdata); else passed++;
    total++; if (count !== 11'h0) $display("FAIL reset_count: got %0d required 0", count); else passed++;
    @(posedge clk); #1;
    rst_n = 1;
  endtask
  task automatic test_add;
    bit ok;
    mem_ready = 0;
    go(10'h010);
    send(2'b00, 2'b00, 4'd1, 4'd2, 4'd0, 1'b1, 28'd5, 1'b1);
    @(negedge clk);
    total++; if (mem_valid !== 1'b1 || mem_addr !== 10'h010) $display("FAIL add_addr: valid=%b addr=%h required 1/010", mem_valid, mem_addr); else passed++;
    total++; if (mem_wdata !== 32'h0120000B) $display("FAIL add_word: got %h required 0120000b", mem_wdata); else passed++;
    total++; if (in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL add_drain: in_ready=%b busy=%b required 0/1", in_ready, busy); else passed++;
    @(posedge clk); #1;
    mem_ready = 1;
    wait_done(ok);
    total++; if (!ok || count !== 11'd1) $display("FAIL add_done: done_seen=%b count=%0d required 1/1", ok, count); else passed++;
  endtask
  task automatic test_load_branch;
    bit ok;
    mem_ready = 1;
    go(10'h020);
    send(2'b01, 2'b00, 4'd3, 4'd4, 4'd5, 1'b0, 28'd0, 1'b0);
    send(2'b10, 2'b10, 4'd0, 4'd0, 4'd0, 1'b0, 28'h100, 1'b1);
    wait_done(ok);
    total++; if (!ok || count !== 11'd2) $display("FAIL lb_done: done_seen=%b count=%0d required 1/2", ok, count); else passed++;
    total++; if (obs_q.size() !== 2) $display("FAIL lb_writes: got %0d required 2", obs_q.size()); else passed++;
    total++; if (obs_q[0] !== {10'h020, 32'h43450000}) $display("FAIL lb_load: got %h required 02043450000", obs_q[0]); else passed++;
    total++; if (obs_q[1] !== {10'h021, 32'hA0000101}) $display("FAIL lb_branch: got %h required 021a0000101", obs_q[1]); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL lb_pulse: done=%b busy=%b required 0/0", done, busy); else passed++;
  endtask
  task automatic test_full;
    bit ok;
    mem_ready = 0;
    go(10'h100);
    for (int i = 0; i < 4; i++) send_rand(1'b0);
    @(negedge clk);
    total++; if (in_ready !== 1'b0 || mem_valid !== 1'b1) $display("FAIL full_ready: in_ready=%b mem_valid=%b required 0/1", in_ready, mem_valid); else passed++;
    total++; if ({mem_addr, mem_wdata} !== exp_q[0]) $display("FAIL full_head: got %h required %h", {mem_addr, mem_wdata}, exp_q[0]); else passed++;
    repeat (3) @(negedge clk);
    total++; if ({mem_addr, mem_wdata} !== exp_q[0] || in_ready !== 1'b0) $display("FAIL full_hold: got %h ready=%b required %h ready=0", {mem_addr, mem_wdata}, in_ready, exp_q[0]); else passed++;
    @(posedge clk); #1;
    mem_ready = 1;
    send_rand(1'b1);
    wait_done(ok);
    total++; if (!ok || obs_q.size() !== 5 || count !== 11'd5) $display("FAIL full_count: done_seen=%b writes=%0d count=%0d required 1/5/5", ok, obs_q.size(), count); else passed++;
    for (int i = 0; i < 5; i++) begin
      total++; if (obs_q[i] !== exp_q[i]) $display("FAIL full_order[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); else passed++;
    end
  endtask
  task automatic test_cache_cmp;
    bit ok;
    mem_ready = 1;
    go(10'h040);
    send(2'b11, 2'b10, 4'd1, 4'd0, 4'd0, 1'b0, 28'h13, 1'b0);
    send(2'b00, 2'b11, 4'd7, 4'd9, 4'd2, 1'b0, 28'd0, 1'b1);
    wait_done(ok);
    total++; if (!ok || enc_err !== 1'b1) $display("FAIL cc_err: done_seen=%b enc_err=%b required 1/1", ok, enc_err); else passed++;
    total++; if (obs_q[0][23:20] !== 4'h3) $display("FAIL cc_cache_field: got %h required 3", obs_q[0][23:20]); else passed++;
    total++; if (obs_q[1][23:20] !== 4'h0) $display("FAIL cc_cmp_rs: got %h required 0", obs_q[1][23:20]); else passed++;
    total++; if (obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) $display("FAIL cc_words: got %h %h required %h %h", obs_q[0], obs_q[1], exp_q[0], exp_q[1]); else passed++;
  endtask
  task automatic test_wrap;
    bit ok;
    mem_ready = 1;
    go(10'h3FF);
    send_rand(1'b0);
    @(posedge clk); #1;
    base_addr = 10'h005;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    send_rand(1'b1);
    wait_done(ok);
    total++; if (!ok || count !== 11'd2 || obs_q.size() !== 2) $display("FAIL wrap_count: done_seen=%b count=%0d writes=%0d required 1/2/2", ok, count, obs_q.size()); else passed++;
    total++; if (obs_q[0][41:32] !== 10'h3FF || obs_q[1][41:32] !== 10'h000) $display("FAIL wrap_addr: got %h %h required 3ff 000", obs_q[0][41:32], obs_q[1][41:32]); else passed++;
    total++; if (obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) $display("FAIL wrap_words: got %h %h required %h %h", obs_q[0], obs_q[1], exp_q[0], exp_q[1]); else passed++;
  endtask
  task automatic test_reset_mid;
    mem_ready = 0;
    go(10'h080);
    send_rand(1'b0);
    send_rand(1'b0);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    total++; if ({in_ready, mem_valid, busy, done, enc_err} !== 5'b0) $display("FAIL rmid_flags: got %b required 00000", {in_ready, mem_valid, busy, done, enc_err}); else passed++;
    total++; if (mem_addr !== 10'h0 || mem_wdata !== 32'h0 || count !== 11'h0) $display("FAIL rmid_regs: addr=%h wdata=%h count=%0d required 0/0/0", mem_addr, mem_wdata, count); else passed++;
    @(posedge clk); #1;
    rst_n = 1;
    mem_ready = 1;
    obs_q.delete();
    repeat (6) @(negedge clk);
    total++; if (obs_q.size() !== 0 || busy !== 1'b0) $display("FAIL rmid_quiet: writes=%0d busy=%b required 0/0", obs_q.size(), busy); else passed++;
  endtask
  task automatic test_random;
    bit ok, stop;
    int n;
    for (int p = 0; p < 4; p++) begin
      n = $urandom_range(1, 10);
      go(10'($urandom));
      stop = 0;
      fork
        begin
          for (int i = 0; i < n; i++) send_rand(i == n - 1);
          wait_done(ok);
          stop = 1;
        end
        begin
          while (!stop) begin
            @(posedge clk); #1;
            mem_ready = 1'($urandom_range(0, 1));
          end
        end
      join
      mem_ready = 1;
      total++; if (!ok || count !== 11'(n) || obs_q.size() !== n) $display("FAIL rand_count[%0d]: done_seen=%b count=%0d writes=%0d required 1/%0d/%0d", p, ok, count, obs_q.size(), n, n); else passed++;
      total++; if (enc_err !== exp_err) $display("FAIL rand_err[%0d]: got %b required %b", p, enc_err, exp_err); else passed++;
      for (int i = 0; i < n; i++) begin
        total++; if (obs_q[i] !== exp_q[i]) $display("FAIL rand_word[%0d.%0d]: got %h required %h", p, i, obs_q[i], exp_q[i]); else passed++;
      end
    end
  endtask
  initial begin
    test_reset;
    test_add;
    test_load_branch;
    test_full;
    test_cache_cmp;
    test_wrap;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
